// File: rtl/ifq_dispatch_if.sv
// Bus between the instruction fetch queue, the decoder and the read-side dispatcher.
// Handshake: instr_out moves to decode on a rising clk edge where
// instr_valid && instr_ready are both high. Once instr_valid rises,
// instr_out and instr_valid hold until that transfer happens; only flush
// or reset may withdraw a pending instruction.
interface ifq_dispatch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    flush;
    logic [1:0]              flush_offset;
    logic                    block_written;
    logic [4*DATA_WIDTH-1:0] instruction_block_in;
    logic [1:0]              selector;
    logic                    queue_full;
    logic                    queue_empty;
    logic [DATA_WIDTH-1:0]   instr_out;
    logic                    instr_valid;
    logic                    instr_ready;
    logic                    block_consumed;
    logic                    overflow_error;

    // Dispatcher side
    modport slave (
        input  flush, flush_offset, block_written, instruction_block_in, instr_ready,
        output selector, queue_full, queue_empty, instr_out, instr_valid,
               block_consumed, overflow_error
    );

    // Queue writer / decode side
    modport master (
        output flush, flush_offset, block_written, instruction_block_in, instr_ready,
        input  selector, queue_full, queue_empty, instr_out, instr_valid,
               block_consumed, overflow_error
    );
endinterface

// File: rtl/ifq_dispatch.sv
// Read-side controller of the 4-row instruction fetch queue: tracks occupancy,
// drives the row selector and issues one instruction per cycle to decode.
module ifq_dispatch #(
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    ifq_dispatch_if.slave      bus,
    output logic [1:0]         state_dbg
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            count;
    logic [1:0]            word_offset;
    logic [1:0]            selector;
    logic [DATA_WIDTH-1:0] instr_out;
    logic                  instr_valid;
    logic                  block_consumed;
    logic                  overflow_error;

    logic                  full;
    logic                  load;
    logic                  pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] cur_word;

    // A new word may enter instr_out when a block is queued and the output
    // register is free or being drained this cycle.
    assign full     = (count == 3'd4);
    assign load     = (count != 3'd0) && (!instr_valid || bus.instr_ready);
    assign pop      = load && (word_offset == 2'd3);
    assign push     = bus.block_written && !full;
    assign cur_word = bus.instruction_block_in[int'(word_offset)*DATA_WIDTH +: DATA_WIDTH];

    // Occupancy, read pointer and output register; flush outranks everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count          <= 3'd0;
            word_offset    <= 2'd0;
            selector       <= 2'd0;
            instr_out      <= '0;
            instr_valid    <= 1'b0;
            block_consumed <= 1'b0;
            overflow_error <= 1'b0;
        end else if (bus.flush) begin
            // flush_offset only affects the first block written afterwards,
            // because the offset wraps to 0 once that block is consumed.
            count          <= 3'd0;
            word_offset    <= bus.flush_offset;
            selector       <= 2'd0;
            instr_valid    <= 1'b0;
            block_consumed <= 1'b0;
            overflow_error <= 1'b0;
        end else begin
            block_consumed <= pop;
            if (bus.block_written && full) begin
                overflow_error <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (load) begin
                instr_out   <= cur_word;
                instr_valid <= 1'b1;
                if (word_offset == 2'd3) begin
                    word_offset <= 2'd0;
                    selector    <= selector + 2'd1;
                end else begin
                    word_offset <= word_offset + 2'd1;
                end
            end else if ((count == 3'd0) && bus.instr_ready) begin
                instr_valid <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: follows whether the output register is idle, issuing or stalled.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (load) state_nxt = ST_ISSUE;
                ST_ISSUE: begin
                    if (!bus.instr_ready) state_nxt = ST_HOLD;
                    else if (!load)       state_nxt = ST_EMPTY;
                end
                ST_HOLD:  if (bus.instr_ready) state_nxt = load ? ST_ISSUE : ST_EMPTY;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign bus.selector       = selector;
    assign bus.queue_full     = full;
    assign bus.queue_empty    = (count == 3'd0);
    assign bus.instr_out      = instr_out;
    assign bus.instr_valid    = instr_valid;
    assign bus.block_consumed = block_consumed;
    assign bus.overflow_error = overflow_error;
    assign state_dbg          = state;
endmodule
